// File: rtl/mips_run_ctrl_if.sv
// Run-control bus between a host and mips_run_ctrl.
// Host side (master) drives run commands, breakpoint settings, the core's
// PC/instruction taps and the trace read index; the controller side (slave)
// returns core reset/enable, run status, cycle count and trace read data.
interface mips_run_ctrl_if #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned PC_W        = 32
);
  localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cycle_limit;
  logic             halt_pc_en;
  logic [PC_W-1:0]  halt_pc;
  logic [PC_W-1:0]  pc_current;
  logic [PC_W-1:0]  instr;
  logic [IDX_W-1:0] trace_rd_idx;

  logic             core_rst;
  logic             core_en;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic [CNT_W-1:0] cycles_run;
  logic [IDX_W:0]   trace_count;
  logic [PC_W-1:0]  trace_rd_pc;
  logic [PC_W-1:0]  trace_rd_instr;

  modport master (
    output start, abort, cycle_limit, halt_pc_en, halt_pc,
           pc_current, instr, trace_rd_idx,
    input  core_rst, core_en, busy, done, status, cycles_run,
           trace_count, trace_rd_pc, trace_rd_instr
  );

  modport slave (
    input  start, abort, cycle_limit, halt_pc_en, halt_pc,
           pc_current, instr, trace_rd_idx,
    output core_rst, core_en, busy, done, status, cycles_run,
           trace_count, trace_rd_pc, trace_rd_instr
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for a MIPS core: resets the core for RST_CYCLES, then
// clock-enables it until a cycle limit, PC breakpoint or abort ends the run.
// Each enabled cycle records {pc, instr} in a circular trace buffer that can
// be read (newest = index 0) with one cycle of registered latency.
// Ports: clk, rst (sync, active high), bus (mips_run_ctrl_if.slave).
// status: 00 none, 01 limit, 10 break, 11 abort.
module mips_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned PC_W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  mips_run_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       status_q, status_d;
  logic [7:0]       rst_cnt_q;
  logic [CNT_W-1:0] cycles_q;
  logic [IDX_W:0]   count_q;
  logic [IDX_W-1:0] wr_ptr_q;
  logic [IDX_W-1:0] rd_addr;
  logic [PC_W-1:0]  rd_pc_q, rd_instr_q;
  logic [PC_W-1:0]  pc_mem    [TRACE_DEPTH];
  logic [PC_W-1:0]  instr_mem [TRACE_DEPTH];

  logic brk, limit_hit, step, launch;

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    step      = 1'b0;
    launch    = 1'b0;
    brk       = bus.halt_pc_en && (bus.pc_current == bus.halt_pc);
    // Compare one bit wider so a saturated counter cannot alias the limit.
    limit_hit = (bus.cycle_limit != '0) &&
                (({1'b0, cycles_q} + (CNT_W+1)'(1)) == {1'b0, bus.cycle_limit});
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RESET;
          status_d = 2'b00;
          launch   = 1'b1;
        end
      end
      RESET: begin
        if (bus.abort) begin
          state_d  = DONE;
          status_d = 2'b11;
        end else if (rst_cnt_q == 8'(RST_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d  = DONE;
          status_d = 2'b11;
        end else if (brk) begin
          state_d  = DONE;
          status_d = 2'b10;
        end else begin
          step = 1'b1;
          if (limit_hit) begin
            state_d  = DONE;
            status_d = 2'b01;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Newest entry sits just behind the write pointer.
  assign rd_addr = wr_ptr_q - IDX_W'(1) - bus.trace_rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      status_q   <= '0;
      rst_cnt_q  <= '0;
      cycles_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_pc_q    <= '0;
      rd_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      rd_pc_q    <= pc_mem[rd_addr];
      rd_instr_q <= instr_mem[rd_addr];
      if (launch) begin
        rst_cnt_q <= '0;
        cycles_q  <= '0;
        count_q   <= '0;
        wr_ptr_q  <= '0;
      end else begin
        if (state_q == RESET) rst_cnt_q <= rst_cnt_q + 8'd1;
        if (step) begin
          if (cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
          if (count_q != (IDX_W+1)'(TRACE_DEPTH)) count_q <= count_q + (IDX_W+1)'(1);
          wr_ptr_q <= wr_ptr_q + IDX_W'(1);
        end
      end
    end
  end

  // Trace storage carries no reset; readers rely on trace_count for validity.
  always_ff @(posedge clk) begin
    if (!rst && step) begin
      pc_mem[wr_ptr_q]    <= bus.pc_current;
      instr_mem[wr_ptr_q] <= bus.instr;
    end
  end

  assign bus.core_rst       = (state_q == IDLE) || (state_q == RESET);
  assign bus.core_en        = step;
  assign bus.busy           = (state_q == RESET) || (state_q == RUN);
  assign bus.done           = (state_q == DONE);
  assign bus.status         = status_q;
  assign bus.cycles_run     = cycles_q;
  assign bus.trace_count    = count_q;
  assign bus.trace_rd_pc    = rd_pc_q;
  assign bus.trace_rd_instr = rd_instr_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a behavioural run model checked every cycle,
// plus directed scenarios with literal expectations. A second instance
// with a 4-bit counter exercises saturation.
module tb_mips_run_ctrl;
  localparam int unsigned DEPTH = 8;
  localparam int          RSTC  = 2;
  localparam int          CMAX  = 65535;

  logic clk, rst;
  int   tests = 0, fails = 0;

  mips_run_ctrl_if #(.CNT_W(16), .TRACE_DEPTH(8), .PC_W(32)) bus ();
  mips_run_ctrl_if #(.CNT_W(4),  .TRACE_DEPTH(8), .PC_W(32)) bus_b ();

  mips_run_ctrl #(.RST_CYCLES(2), .CNT_W(16), .TRACE_DEPTH(8), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  mips_run_ctrl #(.RST_CYCLES(2), .CNT_W(4), .TRACE_DEPTH(8), .PC_W(32)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.start       = bus.start;
  assign bus_b.abort       = bus.abort;
  assign bus_b.pc_current  = bus.pc_current;
  assign bus_b.instr       = bus.instr;
  assign bus_b.cycle_limit = '0;
  assign bus_b.halt_pc_en  = 1'b0;
  assign bus_b.halt_pc     = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return {p[15:0], ~p[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- behavioural model of the run ----------------
  // mode: 0 idle, 1 core held in reset, 2 running, 3 finished
  int          m_mode, m_rleft, m_en_total, m_idx;
  logic [1:0]  m_status;
  logic [63:0] m_trace[$];
  logic        m_valid = 1'b0, m_rd_known, m_hit;
  logic [63:0] m_rd;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_mode = 0; m_en_total = 0; m_status = 2'b00;
      m_trace.delete(); m_rd_known = 1'b1; m_rd = '0;
    end else if (m_valid) begin
      m_idx = int'(bus.trace_rd_idx);
      if (m_idx < m_trace.size()) begin
        m_rd_known = 1'b1; m_rd = m_trace[m_idx];
      end else m_rd_known = 1'b0;
      m_hit = bus.halt_pc_en && (bus.pc_current == bus.halt_pc);
      case (m_mode)
        0, 3: if (bus.start) begin
          m_mode = 1; m_rleft = RSTC; m_en_total = 0; m_status = 2'b00; m_trace.delete();
        end
        1: if (bus.abort) begin m_mode = 3; m_status = 2'b11; end
           else begin m_rleft--; if (m_rleft == 0) m_mode = 2; end
        2: if (bus.abort) begin m_mode = 3; m_status = 2'b11; end
           else if (m_hit) begin m_mode = 3; m_status = 2'b10; end
           else begin
             m_en_total++;
             m_trace.push_front({bus.pc_current, bus.instr});
             if (m_trace.size() > DEPTH) void'(m_trace.pop_back());
             if (bus.cycle_limit != 0 && m_en_total == int'(bus.cycle_limit)) begin
               m_mode = 3; m_status = 2'b01;
             end
           end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("core_rst", 64'(bus.core_rst), 64'(m_mode == 0 || m_mode == 1));
      chk("core_en", 64'(bus.core_en), 64'(m_mode == 2 && !bus.abort &&
          !(bus.halt_pc_en && bus.pc_current == bus.halt_pc)));
      chk("busy", 64'(bus.busy), 64'(m_mode == 1 || m_mode == 2));
      chk("done", 64'(bus.done), 64'(m_mode == 3));
      chk("status", 64'(bus.status), 64'(m_status));
      chk("cycles_run", 64'(bus.cycles_run), 64'((m_en_total > CMAX) ? CMAX : m_en_total));
      chk("trace_count", 64'(bus.trace_count), 64'(m_trace.size()));
      if (m_rd_known) begin
        chk("trace_rd_pc", 64'(bus.trace_rd_pc), 64'(m_rd[63:32]));
        chk("trace_rd_instr", 64'(bus.trace_rd_instr), 64'(m_rd[31:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pc;
  int en_hi, rst_hi, bad_en;

  // Advances one cycle; acts as a trivial core whose PC steps +4 when enabled.
  task automatic tick();
    logic en_s, crst_s;
    @(negedge clk);
    en_s = bus.core_en; crst_s = bus.core_rst;
    if (bus.busy && bus.core_rst) rst_hi++;
    if (bus.core_en) en_hi++;
    if (bus.core_en && bus.halt_pc_en && bus.pc_current == bus.halt_pc) bad_en++;
    @(posedge clk); #1;
    if (crst_s) pc = '0;
    else if (en_s) pc = pc + 32'd4;
    bus.pc_current = pc;
    bus.instr      = instr_of(pc);
  endtask

  task automatic pulse_start();
    en_hi = 0; rst_hi = 0; bad_en = 0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin tick(); n++; end
    chk("done_timeout", 64'(bus.done), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc = '0;
    bus.start = 0; bus.abort = 0; bus.cycle_limit = '0; bus.halt_pc_en = 0;
    bus.halt_pc = '0; bus.pc_current = '0; bus.instr = instr_of(32'd0);
    bus.trace_rd_idx = '0; bus_b.trace_rd_idx = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_core_rst", 64'(bus.core_rst), 64'(1));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_status", 64'(bus.status), 64'(0));
    chk("rst_rd_pc", 64'(bus.trace_rd_pc), 64'(0));

    // Limit run
    bus.cycle_limit = 16'd50;
    pulse_start(); wait_done(200);
    chk("lim_en_cycles", 64'(en_hi), 64'(50));
    chk("lim_rst_cycles", 64'(rst_hi), 64'(2));
    chk("lim_cycles_run", 64'(bus.cycles_run), 64'(50));
    chk("lim_status", 64'(bus.status), 64'(1));
    chk("lim_trace_count", 64'(bus.trace_count), 64'(8));
    bus.trace_rd_idx = 3'd0; tick();
    chk("lim_idx0_pc", 64'(bus.trace_rd_pc), 64'(32'd196));

    // Breakpoint at 0x10
    bus.cycle_limit = 16'd100; bus.halt_pc = 32'h10; bus.halt_pc_en = 1'b1;
    pulse_start(); wait_done(200);
    chk("brk_cycles_run", 64'(bus.cycles_run), 64'(4));
    chk("brk_status", 64'(bus.status), 64'(2));
    chk("brk_trace_count", 64'(bus.trace_count), 64'(4));
    chk("brk_no_en_at_halt", 64'(bad_en), 64'(0));
    bus.trace_rd_idx = 3'd0; tick();
    chk("brk_idx0_pc", 64'(bus.trace_rd_pc), 64'(32'h0C));
    bus.trace_rd_idx = 3'd3; tick();
    chk("brk_idx3_pc", 64'(bus.trace_rd_pc), 64'(32'h00));

    // Break coincides with limit: break wins
    bus.cycle_limit = 16'd5;
    pulse_start(); wait_done(100);
    chk("brk_lim_status", 64'(bus.status), 64'(2));
    chk("brk_lim_cycles", 64'(bus.cycles_run), 64'(4));

    // Abort on the same cycle: abort wins
    pulse_start();
    for (int n = 0; n < 50 && !(bus.busy && !bus.core_rst && bus.pc_current == 32'h10); n++) tick();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("abt_brk_status", 64'(bus.status), 64'(3));
    chk("abt_brk_cycles", 64'(bus.cycles_run), 64'(4));

    // Abort during core reset
    bus.halt_pc_en = 1'b0;
    pulse_start();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("abt_rst_done", 64'(bus.done), 64'(1));
    chk("abt_rst_status", 64'(bus.status), 64'(3));
    chk("abt_rst_cycles", 64'(bus.cycles_run), 64'(0));

    // Reset mid-run
    bus.cycle_limit = '0;
    pulse_start();
    for (int n = 0; n < 100 && bus.cycles_run != 16'd20; n++) tick();
    chk("mid_reached20", 64'(bus.cycles_run), 64'(20));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_core_rst", 64'(bus.core_rst), 64'(1));
    chk("mid_core_en", 64'(bus.core_en), 64'(0));
    chk("mid_busy", 64'(bus.busy), 64'(0));
    chk("mid_done", 64'(bus.done), 64'(0));
    chk("mid_status", 64'(bus.status), 64'(0));
    chk("mid_cycles", 64'(bus.cycles_run), 64'(0));
    chk("mid_trace_count", 64'(bus.trace_count), 64'(0));
    chk("mid_rd_pc", 64'(bus.trace_rd_pc), 64'(0));
    chk("mid_rd_instr", 64'(bus.trace_rd_instr), 64'(0));
    bus.cycle_limit = 16'd3;
    pulse_start(); wait_done(50);
    chk("mid_rerun_cycles", 64'(bus.cycles_run), 64'(3));
    chk("mid_rerun_status", 64'(bus.status), 64'(1));

    // Wrap, saturation and start-while-busy
    rst = 1'b1; tick(); rst = 1'b0;
    bus.cycle_limit = '0;
    pulse_start();
    for (int n = 0; n < 100 && en_hi < 5; n++) tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("start_busy_ignored", 64'(bus.cycles_run), 64'(en_hi));
    for (int n = 0; n < 100 && en_hi < 20; n++) tick();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("wrap_a_cycles", 64'(bus.cycles_run), 64'(20));
    chk("wrap_a_status", 64'(bus.status), 64'(3));
    chk("sat_b_cycles", 64'(bus_b.cycles_run), 64'(15));
    chk("sat_b_status", 64'(bus_b.status), 64'(3));
    chk("sat_b_trace_count", 64'(bus_b.trace_count), 64'(8));
    bus_b.trace_rd_idx = 3'd0; bus.trace_rd_idx = 3'd7; tick();
    chk("sat_b_idx0_pc", 64'(bus_b.trace_rd_pc), 64'(32'd76));
    chk("wrap_a_idx7_pc", 64'(bus.trace_rd_pc), 64'(32'd48));
    bus_b.trace_rd_idx = 3'd7; tick();
    chk("sat_b_idx7_pc", 64'(bus_b.trace_rd_pc), 64'(32'd48));
    chk("sat_b_idx7_instr", 64'(bus_b.trace_rd_instr), 64'(instr_of(32'd48)));

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_run_ctrl.md
MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2: number of cycles core_rst is held high per run; legal range 1 to 255.
REQ-002 SHALL have parameter CNT_W, default 16: width of the cycle limit and cycle counter.
REQ-003 SHALL have parameter TRACE_DEPTH, default 8: number of trace entries; power of two, at least 2.
REQ-004 SHALL have parameter PC_W, default 32: width of the PC and instruction.
REQ-005 SHALL provide ports, one per line:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run.
- abort  in  1  terminates an active run.
- cycle_limit  in  CNT_W  number of enabled cycles to run; 0 means unlimited.
- halt_pc_en  in  1  enables the breakpoint compare.
- halt_pc  in  PC_W  breakpoint address.
- pc_current  in  PC_W  core PC.
- instr  in  PC_W  core instruction.
- trace_rd_idx  in  log2(TRACE_DEPTH)  trace index; 0 is the newest entry.
- core_rst  out  1  reset to the core.
- core_en  out  1  core clock enable.
- busy  out  1  high in RESET or RUN.
- done  out  1  high in DONE.
- status  out  2  00 none, 01 limit, 10 break, 11 abort.
- cycles_run  out  CNT_W  count of enabled cycles.
- trace_count  out  log2(TRACE_DEPTH)+1  number of valid trace entries.
- trace_rd_pc  out  PC_W  PC of the selected entry, registered.
- trace_rd_instr  out  PC_W  instruction of the selected entry, registered.

Function
REQ-006 SHALL implement the FSM states IDLE, RESET, RUN and DONE.
REQ-007 IDLE or DONE with start=1 SHALL enter RESET and, in the same edge, clear cycles_run, trace_count, the write pointer and status.
REQ-008 In RESET, core_rst SHALL be 1 and core_en SHALL be 0, for exactly RST_CYCLES cycles, then the FSM SHALL enter RUN.
REQ-009 In RUN, core_rst=0 and the break condition is (halt_pc_en and pc_current==halt_pc), evaluated combinationally:
- on break: core_en=0 that cycle, no trace write, no count, next state DONE, status=10.
- otherwise: core_en=1, cycles_run increments, and {pc_current, instr} is written at the write pointer.
REQ-010 In RUN, when there is no break and cycle_limit!=0 and cycles_run+1==cycle_limit, the FSM SHALL enter DONE with status=01, so core_en is high for exactly cycle_limit cycles.
REQ-011 abort=1 in RESET or RUN SHALL force core_en=0 that cycle and enter DONE with status=11.
- abort has priority over break, and break over limit.
- abort in IDLE or DONE is ignored.
REQ-012 start while busy SHALL be ignored.
REQ-013 cycles_run SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap; the run continues while saturated.
REQ-014 Trace behaviour:
- the write pointer SHALL wrap modulo TRACE_DEPTH, overwriting the oldest entry.
- trace_count SHALL saturate at TRACE_DEPTH.
- the entry read is (write pointer - 1 - trace_rd_idx) mod TRACE_DEPTH, with 1-cycle registered latency.
- entries with index >= trace_count return undefined data.
REQ-015 The trace SHALL be readable in every state, including during RUN, where a simultaneous write and read returns the pre-write contents.
REQ-016 In IDLE, core_rst=1 and core_en=0; in DONE, core_rst=0 and core_en=0. status and cycles_run SHALL hold in DONE until the next start.

Reset
REQ-017 rst=1 SHALL, on the next edge, from any state including mid-run, set:
- FSM=IDLE, core_rst=1, core_en=0;
- busy=0, done=0, status=00;
- cycles_run=0, trace_count=0, write pointer=0;
- trace_rd_pc=0 and trace_rd_instr=0.
REQ-018 rst SHALL take priority over start and abort; trace storage contents need not be cleared.

Verification
REQ-019 Limit run: defaults, cycle_limit=50, start -> core_rst high 2 cycles, core_en high 50 consecutive cycles, then done=1, status=01, cycles_run=50, trace_count=8, trace idx 0 = PC of the 50th enabled cycle.
REQ-020 Breakpoint: PC steps +4 from 0, halt_pc=0x10, halt_pc_en=1, limit=100 -> cycles_run=4, status=10, core_en never high while pc=0x10, trace idx 0 pc=0x0C, idx 3 pc=0x00, trace_count=4.
REQ-021 Simultaneous events:
- halt_pc matches on the cycle cycles_run+1==cycle_limit -> status=10.
- abort asserted on that same cycle -> status=11.
- abort during RESET -> status=11, cycles_run=0.
REQ-022 Reset mid-run: rst at cycles_run=20 -> next cycle IDLE, core_rst=1, all outputs at reset values; a new start then runs normally from cycles_run=0.
REQ-023 Wrap and saturation:
- CNT_W=4, cycle_limit=0, 20 cycles then abort -> cycles_run=15 (saturated), trace_count=8, idx 0 = 20th PC, idx 7 = 13th PC.
- start while busy -> no effect.
